// File: rtl/axis_ins_arb_pkg.sv
// Shared types for the insert-header round-robin arbiter.
// Holds the packet-level FSM encoding and the grant-index width helper.
package axis_ins_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } arb_state_e;

    // A single source still needs a 1-bit index so port widths never collapse to zero.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_insert_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// Produces both an index and a one-hot form of the winner.
module rr_pick
    import axis_ins_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int SEL_WD  = 1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SEL_WD-1:0]  ptr_i,
    output logic [NUM_SRC-1:0] gnt_oh_o,
    output logic [SEL_WD-1:0]  gnt_idx_o,
    output logic               any_req_o
);

    localparam int SW1 = SEL_WD + 1;

    logic [SW1-1:0]    sum;
    logic [SEL_WD-1:0] idx;

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        gnt_idx_o = '0;
        sum       = '0;
        idx       = '0;
        any_req_o = |req_i;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + SW1'(k);
            idx = (sum >= SW1'(NUM_SRC)) ? SEL_WD'(sum - SW1'(NUM_SRC)) : SEL_WD'(sum);
            if (req_i[idx]) begin
                gnt_idx_o = idx;
            end
        end
        gnt_oh_o = any_req_o ? (NUM_SRC'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/axis_insert_arbiter.sv
// Round-robin front end sharing one insert-header datapath among NUM_SRC sources.
// A grant is held from the header handshake through the payload beat carrying last.
module axis_insert_arbiter
    import axis_ins_arb_pkg::*;
#(
    parameter int  DATA_WD      = 32,
    parameter int  DATA_BYTE_WD = DATA_WD / 8,
    parameter int  NUM_SRC      = 2,
    localparam int SEL_WD       = sel_width(NUM_SRC)
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [NUM_SRC-1:0]               s_valid_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]       s_header_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]  s_keep_insert,
    output logic [NUM_SRC-1:0]               s_ready_insert,

    input  logic [NUM_SRC-1:0]               s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]       s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]  s_keep_in,
    input  logic [NUM_SRC-1:0]               s_last_in,
    output logic [NUM_SRC-1:0]               s_ready_in,

    output logic                             m_valid_insert,
    output logic [DATA_WD-1:0]               m_header_insert,
    output logic [DATA_BYTE_WD-1:0]          m_keep_insert,
    input  logic                             m_ready_insert,

    output logic                             m_valid_in,
    output logic [DATA_WD-1:0]               m_data_in,
    output logic [DATA_BYTE_WD-1:0]          m_keep_in,
    output logic                             m_last_in,
    input  logic                             m_ready_in,

    output logic [SEL_WD-1:0]                grant_id,
    output logic                             busy
);

    arb_state_e          state_q, state_d;
    logic [SEL_WD-1:0]   grant_q, grant_d;
    logic [NUM_SRC-1:0]  grant_oh_q, grant_oh_d;
    logic [SEL_WD-1:0]   rr_q, rr_d;

    logic [NUM_SRC-1:0]  pick_oh;
    logic [SEL_WD-1:0]   pick_idx;
    logic                pick_any;

    logic                    sel_vi;
    logic [DATA_WD-1:0]      sel_hdr;
    logic [DATA_BYTE_WD-1:0] sel_hkeep;
    logic                    sel_vin;
    logic [DATA_WD-1:0]      sel_data;
    logic [DATA_BYTE_WD-1:0] sel_keep;
    logic                    sel_last;

    // Only the header valid counts as a request; payload-only sources never win.
    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_WD  (SEL_WD)
    ) u_rr_pick (
        .req_i     (s_valid_insert),
        .ptr_i     (rr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_req_o (pick_any)
    );

    always_comb begin
        sel_vi    = 1'b0;
        sel_hdr   = '0;
        sel_hkeep = '0;
        sel_vin   = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == SEL_WD'(i)) begin
                sel_vi    = s_valid_insert[i];
                sel_hdr   = s_header_insert[i*DATA_WD +: DATA_WD];
                sel_hkeep = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                sel_vin   = s_valid_in[i];
                sel_data  = s_data_in[i*DATA_WD +: DATA_WD];
                sel_keep  = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                sel_last  = s_last_in[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        grant_oh_d      = grant_oh_q;
        rr_d            = rr_q;
        m_valid_insert  = 1'b0;
        m_header_insert = '0;
        m_keep_insert   = '0;
        s_ready_insert  = '0;
        m_valid_in      = 1'b0;
        m_data_in       = '0;
        m_keep_in       = '0;
        m_last_in       = 1'b0;
        s_ready_in      = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    grant_oh_d = pick_oh;
                    state_d    = HDR;
                end
            end
            HDR: begin
                m_valid_insert = sel_vi;
                if (sel_vi) begin
                    m_header_insert = sel_hdr;
                    m_keep_insert   = sel_hkeep;
                end
                s_ready_insert = grant_oh_q & {NUM_SRC{m_ready_insert}};
                if (sel_vi && m_ready_insert) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                m_valid_in = sel_vin;
                if (sel_vin) begin
                    m_data_in = sel_data;
                    m_keep_in = sel_keep;
                    m_last_in = sel_last;
                end
                s_ready_in = grant_oh_q & {NUM_SRC{m_ready_in}};
                // Pointer moves past the finished source so the others get the next turn.
                if (sel_vin && m_ready_in && sel_last) begin
                    state_d = IDLE;
                    rr_d    = (grant_q == SEL_WD'(NUM_SRC - 1)) ? '0 : grant_q + SEL_WD'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_q       <= rr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_axis_insert_arbiter.sv
// Bench for axis_insert_arbiter: packet-driven sources, a cycle model of the
// arbitration rules checked every cycle, and directed literal expectations.
module tb_axis_insert_arbiter;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int NS = 2;
    localparam int SW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NS-1:0]    s_valid_insert  = '0;
    logic [NS*DW-1:0] s_header_insert = '0;
    logic [NS*KW-1:0] s_keep_insert   = '0;
    logic [NS-1:0]    s_ready_insert;
    logic [NS-1:0]    s_valid_in = '0;
    logic [NS*DW-1:0] s_data_in  = '0;
    logic [NS*KW-1:0] s_keep_in  = '0;
    logic [NS-1:0]    s_last_in  = '0;
    logic [NS-1:0]    s_ready_in;
    logic             m_valid_insert;
    logic [DW-1:0]    m_header_insert;
    logic [KW-1:0]    m_keep_insert;
    logic             m_ready_insert = 1'b1;
    logic             m_valid_in;
    logic [DW-1:0]    m_data_in;
    logic [KW-1:0]    m_keep_in;
    logic             m_last_in;
    logic             m_ready_in = 1'b1;
    logic [SW-1:0]    grant_id;
    logic             busy;

    axis_insert_arbiter #(.DATA_WD(DW), .DATA_BYTE_WD(KW), .NUM_SRC(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid_insert(s_valid_insert), .s_header_insert(s_header_insert),
        .s_keep_insert(s_keep_insert), .s_ready_insert(s_ready_insert),
        .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
        .s_last_in(s_last_in), .s_ready_in(s_ready_in),
        .m_valid_insert(m_valid_insert), .m_header_insert(m_header_insert),
        .m_keep_insert(m_keep_insert), .m_ready_insert(m_ready_insert),
        .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
        .m_last_in(m_last_in), .m_ready_in(m_ready_in),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] hdr;
        logic [KW-1:0] hkeep;
        int            nb;
        logic [DW-1:0] base;
        logic [KW-1:0] lkeep;
    } pkt_t;

    function automatic pkt_t mk(logic [DW-1:0] h, logic [KW-1:0] hk, int nb,
                                logic [DW-1:0] b, logic [KW-1:0] lk);
        pkt_t p;
        p.hdr = h; p.hkeep = hk; p.nb = nb; p.base = b; p.lkeep = lk;
        return p;
    endfunction

    pkt_t q [NS][$];
    pkt_t cur [NS];
    bit   act [NS];
    bit   hdone [NS];
    int   bidx [NS];
    bit   vin1_only = 1'b0;

    // Observations at the master side
    int            cyc = 0;
    int            grant_log[$];
    logic [DW-1:0] hdr_log[$];
    logic [KW-1:0] hkeep_log[$];
    int            hv_log[$];
    int            lastc_log[$];
    int            beats;
    logic [KW-1:0] last_keep;
    logic          last_mvi, prev_mvi;
    logic [DW-1:0] last_mdata;
    bit            busy_seen;

    task automatic clear_logs();
        grant_log.delete(); hdr_log.delete(); hkeep_log.delete();
        hv_log.delete(); lastc_log.delete();
        beats = 0; last_keep = '0; busy_seen = 0; prev_mvi = 0;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NS; i++) begin
            act[i] = 0; hdone[i] = 0; bidx[i] = 0; q[i].delete();
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NS; i++) if (act[i] || q[i].size() != 0) return 1;
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (!act[i] && q[i].size() != 0) begin
                cur[i] = q[i].pop_front();
                act[i] = 1; hdone[i] = 0; bidx[i] = 0;
            end
            s_valid_insert[i]         = act[i] && !hdone[i];
            s_header_insert[i*DW +: DW] = act[i] ? cur[i].hdr : '0;
            s_keep_insert[i*KW +: KW]   = act[i] ? cur[i].hkeep : '0;
            s_valid_in[i]             = act[i] || (i == 1 && vin1_only);
            s_data_in[i*DW +: DW]     = act[i] ? cur[i].base + DW'(bidx[i]) : 32'hDEAD_0000 + DW'(i);
            s_keep_in[i*KW +: KW]     = (act[i] && bidx[i] == cur[i].nb - 1) ? cur[i].lkeep : 4'hF;
            s_last_in[i]              = act[i] && (bidx[i] == cur[i].nb - 1);
        end
    endtask

    task automatic cycle();
        bit hh [NS];
        bit hd [NS];
        drive();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NS; i++) begin
            hh[i] = s_valid_insert[i] && s_ready_insert[i];
            hd[i] = s_valid_in[i] && s_ready_in[i];
        end
        if (m_valid_insert && m_ready_insert) begin
            grant_log.push_back(int'(grant_id));
            hdr_log.push_back(m_header_insert);
            hkeep_log.push_back(m_keep_insert);
        end
        if (m_valid_insert && !prev_mvi) hv_log.push_back(cyc);
        prev_mvi   = m_valid_insert;
        last_mvi   = m_valid_insert;
        last_mdata = m_data_in;
        if (m_valid_in && m_ready_in) begin
            beats++;
            if (m_last_in) begin
                last_keep = m_keep_in;
                lastc_log.push_back(cyc);
            end
        end
        if (busy) busy_seen = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (act[i]) begin
                if (hh[i]) hdone[i] = 1;
                if (hd[i]) begin
                    if (bidx[i] == cur[i].nb - 1) act[i] = 0;
                    else bidx[i]++;
                end
            end
        end
    endtask

    task automatic run_idle(input int max, input string nm);
        int n = 0;
        while (pending() && n < max) begin
            cycle();
            n++;
        end
        chk({nm, "_completed_in_budget"}, 64'(n < max), 64'd1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_src();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    // Reference model of the arbitration rules, checked on every falling edge
    int mph = 0;
    int mg = 0;
    int mptr = 0;
    logic          e_vi, e_vin;
    logic [NS-1:0] e_sri, e_srn;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mph = 0; mg = 0; mptr = 0;
                chk("reset_outputs",
                    {busy, grant_id, m_valid_insert, m_valid_in, s_ready_insert, s_ready_in}, 64'd0);
            end else begin
                e_vi  = (mph == 1) && s_valid_insert[mg];
                e_vin = (mph == 2) && s_valid_in[mg];
                e_sri = (mph == 1 && m_ready_insert) ? (NS'(1) << mg) : '0;
                e_srn = (mph == 2 && m_ready_in) ? (NS'(1) << mg) : '0;
                chk("ctrl",
                    {busy, grant_id, m_valid_insert, m_valid_in, s_ready_insert, s_ready_in},
                    {(mph != 0), SW'(mg), e_vi, e_vin, e_sri, e_srn});
                chk("hdr_mux", {m_header_insert, m_keep_insert},
                    e_vi ? {s_header_insert[mg*DW +: DW], s_keep_insert[mg*KW +: KW]} : '0);
                chk("data_mux", {m_data_in, m_keep_in, m_last_in},
                    e_vin ? {s_data_in[mg*DW +: DW], s_keep_in[mg*KW +: KW], s_last_in[mg]} : '0);
                if (mph == 0) begin
                    for (int k = 0; k < NS; k++) begin
                        if (mph == 0 && s_valid_insert[(mptr + k) % NS]) begin
                            mg  = (mptr + k) % NS;
                            mph = 1;
                        end
                    end
                end else if (mph == 1) begin
                    if (e_vi && m_ready_insert) mph = 2;
                end else begin
                    if (e_vin && m_ready_in && s_last_in[mg]) begin
                        mph  = 0;
                        mptr = (mg + 1) % NS;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int n;
    int exp_order [4] = '{0, 1, 0, 1};
    logic [DW-1:0] exp_hdrs [4] = '{32'h5000_0000, 32'h5000_0100, 32'h5000_0001, 32'h5000_0101};

    initial begin
        clear_src();
        clear_logs();

        // Reset state
        repeat (3) cycle();
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_valids", {m_valid_insert, m_valid_in}, 0);
        rst_n = 1'b1;
        cycle();

        // Source 0 alone: one-cycle request latency, header/keep and four beats
        clear_logs();
        q[0].push_back(mk(32'hA5A5_A5A5, 4'b0011, 4, 32'h1000_0000, 4'b1100));
        cycle();
        chk("t1_mvi_request_cycle", last_mvi, 0);
        cycle();
        chk("t1_mvi_next_cycle", last_mvi, 1);
        chk("t1_grant_id", grant_id, 0);
        run_idle(50, "t1");
        chk("t1_header", hdr_log.size() > 0 ? hdr_log[0] : '0, 32'hA5A5_A5A5);
        chk("t1_hkeep", hkeep_log.size() > 0 ? hkeep_log[0] : '0, 4'b0011);
        chk("t1_beats", beats, 4);
        chk("t1_last_keep", last_keep, 4'b1100);
        chk("t1_busy_after_last", busy, 0);

        // Simultaneous request after reset: src0 first, one idle cycle, then src1
        apply_reset();
        clear_logs();
        q[0].push_back(mk(32'h0000_0B00, 4'hF, 2, 32'h2000_0000, 4'hF));
        q[1].push_back(mk(32'h0000_0B01, 4'hF, 2, 32'h2100_0000, 4'hF));
        run_idle(50, "t2");
        chk("t2_grant_count", grant_log.size(), 2);
        chk("t2_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        chk("t2_second_grant", grant_log.size() > 1 ? grant_log[1] : -1, 1);
        chk("t2_idle_gap", (hv_log.size() > 1 && lastc_log.size() > 0) ? hv_log[1] - lastc_log[0] : -1, 2);

        // Continuous requests: four packets alternate 0,1,0,1
        clear_logs();
        q[0].push_back(mk(32'h5000_0000, 4'hF, 2, 32'h3000_0000, 4'hF));
        q[0].push_back(mk(32'h5000_0001, 4'hF, 2, 32'h3001_0000, 4'hF));
        q[1].push_back(mk(32'h5000_0100, 4'hF, 2, 32'h3100_0000, 4'hF));
        q[1].push_back(mk(32'h5000_0101, 4'hF, 2, 32'h3101_0000, 4'hF));
        run_idle(80, "t3");
        chk("t3_grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_order_%0d", k), grant_log.size() > k ? grant_log[k] : -1, exp_order[k]);
            chk($sformatf("t3_hdr_%0d", k), hdr_log.size() > k ? hdr_log[k] : '0, exp_hdrs[k]);
        end

        // Backpressure mid-body: ready withheld three cycles, data held
        clear_logs();
        q[0].push_back(mk(32'h4444_0000, 4'hF, 4, 32'h4000_0000, 4'hF));
        n = 0;
        while (!(act[0] && hdone[0] && bidx[0] == 1) && n < 20) begin
            cycle();
            n++;
        end
        chk("t4_reached_beat1", 64'(n < 20), 1);
        m_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("t4_data_held_%0d", k), last_mdata, 32'h4000_0001);
        end
        m_ready_in = 1'b1;
        run_idle(50, "t4");
        chk("t4_beats", beats, 4);

        // Payload valid without header request is never granted
        clear_logs();
        vin1_only = 1'b1;
        repeat (20) cycle();
        vin1_only = 1'b0;
        chk("t5_never_busy", busy_seen, 0);
        chk("t5_no_grant", grant_log.size(), 0);
        chk("t5_no_beats", beats, 0);

        // Asynchronous reset during src1's third beat, then src0 wins again
        clear_logs();
        q[1].push_back(mk(32'h6666_0000, 4'hF, 4, 32'h6000_0000, 4'hF));
        n = 0;
        while (!(act[1] && bidx[1] == 2) && n < 20) begin
            cycle();
            n++;
        end
        chk("t6_reached_beat2", 64'(n < 20), 1);
        chk("t6_busy_before_reset", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_mvin_on_reset", m_valid_in, 0);
        chk("t6_busy_on_reset", busy, 0);
        chk("t6_grant_on_reset", grant_id, 0);
        clear_src();
        repeat (2) cycle();
        rst_n = 1'b1;
        clear_logs();
        q[0].push_back(mk(32'h7700_0000, 4'hF, 2, 32'h7000_0000, 4'hF));
        q[1].push_back(mk(32'h7700_0001, 4'hF, 2, 32'h7100_0000, 4'hF));
        run_idle(50, "t6");
        chk("t6_first_after_reset", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        chk("t6_second_after_reset", grant_log.size() > 1 ? grant_log[1] : -1, 1);

        repeat (2) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_insert_arbiter.md
Name: axis_insert_arbiter

Overview:
Round-robin scheduler that shares one axi_stream_insert_header datapath between NUM_SRC independent header+payload sources. It grants one source per packet and locks the grant from header handshake through the payload beat carrying last. It routes the granted source's insert and data channels to the shared block and returns ready only to that source. It sits directly upstream of the insert-header block.

Parameters:
DATA_WD, 32, payload/header width in bits
DATA_BYTE_WD, DATA_WD/8, keep width
NUM_SRC, 2, number of requesting sources (2..8)
SEL_WD, $clog2(NUM_SRC), grant index width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_valid_insert  in  NUM_SRC  per-source header valid (the request)
s_header_insert  in  NUM_SRC*DATA_WD  per-source header, source i at slice i
s_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep
s_ready_insert  out  NUM_SRC  per-source header ready
s_valid_in  in  NUM_SRC  per-source payload valid
s_data_in  in  NUM_SRC*DATA_WD  per-source payload
s_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source payload keep
s_last_in  in  NUM_SRC  per-source payload last
s_ready_in  out  NUM_SRC  per-source payload ready
m_valid_insert / m_header_insert / m_keep_insert  out  1 / DATA_WD / DATA_BYTE_WD  to shared block
m_ready_insert  in  1  from shared block
m_valid_in / m_data_in / m_keep_in / m_last_in  out  1 / DATA_WD / DATA_BYTE_WD / 1  to shared block
m_ready_in  in  1  from shared block
grant_id  out  SEL_WD  current or last granted source
busy  out  1  a packet is in progress (state HDR or BODY)

Behaviour:
- Reset values: state IDLE, grant_id 0, rr pointer 0, busy 0. All m_valid_* are 0 and all s_ready_* are 0. Reset takes effect immediately on rst_n low.
- Eligibility: a source is eligible only when s_valid_insert[i] is 1. A source asserting valid_in alone is never granted.
- IDLE: if any source is eligible, pick the first eligible source at or after the rr pointer, wrapping modulo NUM_SRC. Register it into grant_id and go to HDR. Latency from request to m_valid_insert is 1 cycle.
- HDR: m_*_insert = granted source's insert channel. s_ready_insert[g] = m_ready_insert; all other ready outputs are 0. m_valid_in = 0 and s_ready_in = 0 for all sources, so payload beats wait for the header. On an m_valid_insert and m_ready_insert handshake, go to BODY.
- BODY: m_*_in = granted source's payload channel. s_ready_in[g] = m_ready_in; all other ready outputs are 0. m_valid_insert = 0. On a handshake with s_last_in[g] = 1: go to IDLE and set rr pointer = g+1, wrapping to 0 at NUM_SRC.
- Grant is locked in HDR and BODY. Deasserting the granted valid only stalls; it never causes re-arbitration. Requests from other sources are held by the sources and are not dropped.
- There is one IDLE cycle between packets; back-to-back packets with no gap are not supported.
- Output muxes are combinational from grant_id and state. The data, header and keep outputs are don't-care when their valid is 0 but are driven to 0.
- Simultaneous requests: resolved purely by rr pointer order. After reset, source 0 has priority.

Decomposition:
- Package axis_ins_arb_pkg: state enum {IDLE, HDR, BODY} and a NUM_SRC-to-SEL_WD width helper.
- Sub-module rr_pick: combinational request vector + pointer -> one-hot/index grant and any_req. It is instanced once.
- The FSM, grant register and muxes live in the top module.

Test Plan:
- Src0 only: header 0xA5A5A5A5, keep 4'b0011, then 4 beats with last beat keep 4'b1100 -> grant_id=0; m_valid_insert rises 1 cycle after request; s_ready_in[1]=0 throughout; busy falls after the last handshake.
- Src0 and src1 request in the same cycle after reset -> src0 served first. After src0's last beat, 1 IDLE cycle, then grant_id=1.
- Both request continuously for 4 packets -> grant order 0,1,0,1.
- m_ready_in=0 for 3 cycles mid-BODY -> s_ready_in[g]=0 for those cycles; m_data_in is held; beat count out equals beat count in (4).
- Src1 holds s_valid_in=1 with s_valid_insert=0 for 20 cycles -> never granted; s_ready_in[1]=0 throughout.
- rst_n low during BODY beat 2 -> m_valid_in=0 and busy=0 immediately. After release, both sources request and src0 is granted first.
